// File: rtl/line_buf_ctrl_if.sv
// Pixel-stream and two-RAM line-buffer bus between line_buf_ctrl and its neighbours.
// master: the sequencer (consumes the stream, drives RAM controls and window info).
interface line_buf_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 10
);
  logic              sof;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_in;
  logic [DATA_W-1:0] datain;
  logic              rama_wren;
  logic              ramb_wren;
  logic              rama_rden;
  logic              ramb_rden;
  logic [ADDR_W-1:0] rama_wradd;
  logic [ADDR_W-1:0] ramb_wradd;
  logic [ADDR_W-1:0] rama_rdadd;
  logic [ADDR_W-1:0] ramb_rdadd;
  logic [DATA_W-1:0] pix_dly;
  logic              line_sel;
  logic              win_valid;
  logic [ADDR_W-1:0] x_pos;
  logic [15:0]       y_pos;
  logic              eof;
  logic              frame_err;

  modport master (
    input  sof, pix_valid, pix_in,
    output datain, rama_wren, ramb_wren, rama_rden, ramb_rden,
           rama_wradd, ramb_wradd, rama_rdadd, ramb_rdadd,
           pix_dly, line_sel, win_valid, x_pos, y_pos, eof, frame_err
  );

  modport slave (
    output sof, pix_valid, pix_in,
    input  datain, rama_wren, ramb_wren, rama_rden, ramb_rden,
           rama_wradd, ramb_wradd, rama_rdadd, ramb_rdadd,
           pix_dly, line_sel, win_valid, x_pos, y_pos, eof, frame_err
  );
endinterface

// File: rtl/line_buf_ctrl.sv
// Address/enable sequencer for the ping-pong two-RAM line buffer feeding the 3x3 Sobel stage.
// Optional: define LB_BORDER_MASK_EN to drop win_valid on the first and last column.
module line_buf_ctrl #(
  parameter int LINE_WIDTH   = 1280,
  parameter int FRAME_HEIGHT = 1024,
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 10,
  parameter int RD_LAT       = 1
) (
  input  logic           clk,
  input  logic           rst,
  line_buf_ctrl_if.master lb
);

  localparam logic [ADDR_W-1:0] XMAX = ADDR_W'(LINE_WIDTH - 1);
  localparam logic [15:0]       YMAX = 16'(FRAME_HEIGHT - 1);

  if (LINE_WIDTH > (2 ** ADDR_W)) begin : g_bad_width
    $error("line_buf_ctrl: LINE_WIDTH exceeds 2**ADDR_W");
  end

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] x_q, x_d;
  logic [15:0]       y_q, y_d;

  logic              restart, acc, last_px, win_now;
  logic [ADDR_W-1:0] cur_x;
  logic [15:0]       cur_y;

  logic              wren_a_q, wren_b_q, eof_q, ferr_q;
  logic [ADDR_W-1:0] wradd_q;

  logic [RD_LAT-1:0]             win_pipe, sel_pipe;
  logic [RD_LAT-1:0][DATA_W-1:0] pix_pipe;
  logic [RD_LAT-1:0][ADDR_W-1:0] x_pipe;
  logic [RD_LAT-1:0][15:0]       y_pipe;

  // Pixel acceptance and coordinates; a restart pixel is always (0,0) regardless of counters.
  always_comb begin
    restart = lb.sof & lb.pix_valid & ~rst;
    acc     = lb.pix_valid & ~rst & (restart | (state_q != IDLE));
    cur_x   = restart ? '0 : x_q;
    cur_y   = restart ? '0 : y_q;
    last_px = (cur_x == XMAX) && (cur_y == YMAX);
`ifdef LB_BORDER_MASK_EN
    win_now = (cur_y >= 16'd2) && (cur_x != '0) && (cur_x != XMAX);
`else
    win_now = (cur_y >= 16'd2);
`endif
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    if (acc) begin
      if (last_px) begin
        state_d = IDLE;
        x_d     = '0;
        y_d     = '0;
      end else if (cur_x == XMAX) begin
        x_d     = '0;
        y_d     = cur_y + 16'd1;
        state_d = (cur_y + 16'd1 >= 16'd2) ? RUN : FILL;
      end else begin
        x_d     = cur_x + 1'b1;
        y_d     = cur_y;
        state_d = (cur_y >= 16'd2) ? RUN : FILL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Writes lag reads by one cycle so the old row-(y-2) word is read before it is overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wren_a_q <= 1'b0;
      wren_b_q <= 1'b0;
      wradd_q  <= '0;
      eof_q    <= 1'b0;
      ferr_q   <= 1'b0;
      win_pipe <= '0;
      sel_pipe <= '0;
      pix_pipe <= '0;
      x_pipe   <= '0;
      y_pipe   <= '0;
    end else begin
      wren_a_q <= acc & ~cur_y[0];
      wren_b_q <= acc &  cur_y[0];
      if (acc) wradd_q <= cur_x;
      eof_q    <= acc & last_px;
      ferr_q   <= restart & (state_q != IDLE);
      for (int i = RD_LAT - 1; i > 0; i--) begin
        win_pipe[i] <= win_pipe[i-1];
        sel_pipe[i] <= sel_pipe[i-1];
        pix_pipe[i] <= pix_pipe[i-1];
        x_pipe[i]   <= x_pipe[i-1];
        y_pipe[i]   <= y_pipe[i-1];
      end
      win_pipe[0] <= acc & win_now;
      sel_pipe[0] <= acc & cur_y[0];
      pix_pipe[0] <= acc ? lb.pix_in : '0;
      x_pipe[0]   <= acc ? cur_x : '0;
      y_pipe[0]   <= acc ? cur_y : '0;
    end
  end

  // datain is a pass-through, but held at 0 during reset like every other output.
  assign lb.datain     = rst ? '0 : lb.pix_in;
  assign lb.rama_rden  = acc;
  assign lb.ramb_rden  = acc;
  assign lb.rama_rdadd = acc ? cur_x : '0;
  assign lb.ramb_rdadd = acc ? cur_x : '0;
  assign lb.rama_wren  = wren_a_q;
  assign lb.ramb_wren  = wren_b_q;
  assign lb.rama_wradd = wradd_q;
  assign lb.ramb_wradd = wradd_q;
  assign lb.pix_dly    = pix_pipe[RD_LAT-1];
  assign lb.line_sel   = sel_pipe[RD_LAT-1];
  assign lb.win_valid  = win_pipe[RD_LAT-1];
  assign lb.x_pos      = x_pipe[RD_LAT-1];
  assign lb.y_pos      = y_pipe[RD_LAT-1];
  assign lb.eof        = eof_q;
  assign lb.frame_err  = ferr_q;

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Directed bench for line_buf_ctrl (8x4 frame, RD_LAT=1) with a small registered two-RAM buffer model.
module tb_line_buf_ctrl;
  localparam int LW = 8, FH = 4, AW = 11, DW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_buf_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) lb();

  line_buf_ctrl #(
    .LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .lb (lb)
  );

  // Buffer model: input register on datain, registered read ports.
  logic [DW-1:0] ram_a [LW];
  logic [DW-1:0] ram_b [LW];
  logic [DW-1:0] din_q, q_a, q_b;
  always @(posedge clk) begin
    din_q <= lb.datain;
    if (lb.rama_rden) q_a <= ram_a[lb.rama_rdadd[2:0]];
    if (lb.ramb_rden) q_b <= ram_b[lb.ramb_rdadd[2:0]];
    if (lb.rama_wren) ram_a[lb.rama_wradd[2:0]] <= din_q;
    if (lb.ramb_wren) ram_b[lb.ramb_wradd[2:0]] <= din_q;
  end

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input int d);
    lb.pix_valid = v;
    lb.sof       = s;
    lb.pix_in    = DW'(d);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Registered outputs one cycle after pixel (row,col) of value val.
  task automatic chk_out(input int val, input int row, input int col);
    logic w;
    w = (row >= 2);
`ifdef LB_BORDER_MASK_EN
    w = w && (col != 0) && (col != LW - 1);
`endif
    chk("wren_a",   lb.rama_wren, (row % 2) == 0);
    chk("wren_b",   lb.ramb_wren, (row % 2) == 1);
    chk("wradd_a",  lb.rama_wradd, col);
    chk("wradd_b",  lb.ramb_wradd, col);
    chk("pix_dly",  lb.pix_dly, val);
    chk("x_pos",    lb.x_pos, col);
    chk("y_pos",    lb.y_pos, row);
    chk("line_sel", lb.line_sel, row % 2);
    chk("win",      lb.win_valid, w);
  endtask

  initial begin
    int p, r, c, ea, eb;
    lb.sof = 1'b0; lb.pix_valid = 1'b0; lb.pix_in = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rden", lb.rama_rden, 0);
    chk("rst_wren", lb.rama_wren, 0);
    chk("rst_eof",  lb.eof, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Short stream, then reset mid-stream with sof+pix_valid still high.
    drive(1, 1, 5); step();
    drive(1, 0, 6); step();
    drive(1, 0, 7);
    @(negedge clk);
    chk("pre_rst_pix", lb.pix_dly, 6);
    #1 rst = 1'b1;
    lb.sof = 1'b1;
    #1;
    chk("rst_rden_a", lb.rama_rden, 0);
    chk("rst_rden_b", lb.ramb_rden, 0);
    chk("rst_rdadd",  lb.rama_rdadd, 0);
    chk("rst_wren_a", lb.rama_wren, 0);
    chk("rst_wradd",  lb.rama_wradd, 0);
    chk("rst_pix",    lb.pix_dly, 0);
    chk("rst_xpos",   lb.x_pos, 0);
    chk("rst_ypos",   lb.y_pos, 0);
    chk("rst_win",    lb.win_valid, 0);
    chk("rst_datain", lb.datain, 0);
    chk("rst_ferr",   lb.frame_err, 0);
    step();
    rst = 1'b0;
    drive(1, 0, 9);
    @(negedge clk);
    chk("ign_rden", lb.rama_rden, 0);
    step();
    drive(0, 0, 0);
    @(negedge clk);
    chk("ign_wren_a", lb.rama_wren, 0);
    chk("ign_wren_b", lb.ramb_wren, 0);
    step();

    // Full 8x4 frame, values 0..31.
    for (int i = 0; i <= 32; i++) begin
      if (i < 32) drive(1, i == 0, i);
      else        drive(0, 0, 0);
      @(negedge clk);
      if (i < 32) begin
        chk("rden_a", lb.rama_rden, 1);
        chk("rden_b", lb.ramb_rden, 1);
        chk("rdadd",  lb.rama_rdadd, i % LW);
      end
      if (i > 0) begin
        p = i - 1; r = p / LW; c = p % LW;
        chk_out(p, r, c);
        chk("ferr", lb.frame_err, 0);
        if (r >= 2) begin
          ea = ((r - 1) % 2 == 0) ? (r - 1) * LW + c : (r - 2) * LW + c;
          eb = ((r - 1) % 2 == 1) ? (r - 1) * LW + c : (r - 2) * LW + c;
          chk("q_a", q_a, ea);
          chk("q_b", q_b, eb);
        end
      end
      chk("eof", lb.eof, i == 32);
      step();
    end
    // Back in IDLE: a pixel without sof is ignored, eof was a single pulse.
    drive(1, 0, 50);
    @(negedge clk);
    chk("eof_pulse", lb.eof, 0);
    chk("idle_rden", lb.rama_rden, 0);
    step();
    drive(0, 0, 0);
    @(negedge clk);
    chk("idle_wren_a", lb.rama_wren, 0);
    chk("idle_wren_b", lb.ramb_wren, 0);
    step();

    // New frame interrupted by sof at row 1, col 3.
    for (int i = 0; i < 11; i++) begin
      drive(1, i == 0, 200 + i);
      step();
    end
    drive(1, 1, 100);
    @(negedge clk);
    chk("restart_rdadd", lb.rama_rdadd, 0);
    step();
    for (int j = 1; j <= 18; j++) begin
      if (j <= 17) drive(1, 0, 100 + j);
      else         drive(0, 0, 0);
      @(negedge clk);
      chk_out(100 + j - 1, (j - 1) / LW, (j - 1) % LW);
      if (j == 1) chk("ferr_pulse", lb.frame_err, 1);
      if (j == 2) chk("ferr_clear", lb.frame_err, 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
